down_counter_seq: RTL and testbench
===================================

Name: down_counter_seq

Overview:
- Loadable down-counter sequencer; the counting-down counterpart to the team's loadable up-counter with terminal-count carry.
- Accepts a start count through a ready/start handshake, decrements on enable, and signals completion with borrow-out and a one-cycle done pulse.
- Used by convolution control to track the number of remaining elements, rows or kernel taps.
- Chainable: one block's bout/done can drive another block's en/start.

Parameters:
- WIDTH, 4, counter width in bits.
- AUTO_RELOAD, 0, 1 = restart automatically from the stored load value after each done.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- start  input  1  load request; accepted only when ready=1.
- ld_val  input  WIDTH  start count, sampled when start is accepted.
- en  input  1  decrement enable; acts only in RUN.
- abort  input  1  cancel the current count; acts in RUN and DONE.
- out  output  WIDTH  current count (registered).
- bout  output  1  borrow-out; combinational, high when out==0.
- ready  output  1  high when state==IDLE.
- busy  output  1  high when state==RUN.
- done  output  1  high when state==DONE, i.e. exactly one cycle per completed count.

Behaviour:
- State register: IDLE, RUN, DONE. A reload register rl[WIDTH-1:0] holds the accepted ld_val.
- Reset (rst=0, asynchronous): state=IDLE, out=0, rl=0.
  - While in reset: ready=1, busy=0, done=0, bout=1.
- IDLE:
  - start=1 and ld_val!=0: out<=ld_val, rl<=ld_val, go to RUN.
  - start=1 and ld_val==0: out<=0, rl<=0, go to DONE (zero-length count).
  - start=0: hold everything.
  - en and abort are ignored.
- RUN, with priority abort > en:
  - abort=1: out<=0, go to IDLE, no done pulse.
  - en=1 and out>1: out<=out-1.
  - en=1 and out==1: out<=0, go to DONE.
  - en=0: hold.
  - start is ignored. ld_val is not resampled.
- DONE (lasts exactly one cycle):
  - abort=1: go to IDLE.
  - Otherwise, AUTO_RELOAD=1 and rl!=0: out<=rl, go to RUN.
  - Otherwise go to IDLE. out stays 0.
  - The en value during DONE is ignored; no decrement happens.
- Latency: N=ld_val>0 needs exactly N en-active RUN cycles after the load cycle.
  - done rises on the clock edge that applies the N-th decrement.
  - ready returns one cycle after done (AUTO_RELOAD=0).
- Wrap-around: out never decrements below 0; 0 is reachable only through the out==1 transition, abort or reset. There is no underflow wrap.
- Arithmetic: unsigned, modulo 2^WIDTH. The maximum count is 2^WIDTH-1.
- bout depends only on out. It is high in IDLE after a completed count and after reset.
- Asserting rst mid-count forces IDLE/out=0 immediately (asynchronous). No done pulse follows.
- Simultaneous start in the same cycle as done: start is ignored because ready=0. It is accepted on the next cycle once ready=1.
- All registers update on the clk rising edge only, except the asynchronous reset.

Test Plan:
- Reset mid-RUN: load 9, run 3 en cycles, pull rst=0 between edges -> out=0, ready=1, busy=0, bout=1 immediately; no done afterwards.
- Basic count: ld_val=5, start 1 cycle, en held 1 -> out 5,4,3,2,1,0; done high 1 cycle coinciding with out=0; ready=1 next cycle; done asserted exactly once.
- Gapped enable: ld_val=3, en toggles 1,0,0,1,0,1 -> out 3,2,2,2,1,1,0; done only after the third en.
- Zero load and max: ld_val=0 -> done the cycle after start, out=0, no RUN. ld_val=15 (WIDTH=4) -> 15 en cycles to done, no wrap.
- Abort priority: ld_val=6, 2 en cycles, then abort=1 with en=1 -> out=0, state IDLE, done never asserted; the following start with ld_val=2 is accepted normally.
- AUTO_RELOAD=1: ld_val=2, en continuous -> out 2,1,0,2,1,0 with done every 3rd cycle; abort during DONE -> IDLE, ready=1, out=0.

Source files
------------

// File: rtl/down_counter_seq.sv
// ---------------------------------------------------------------------------
// down_counter_seq
//
// Loadable down-counter sequencer. A start count is accepted through a
// ready/start handshake, decremented on en while running, and completion is
// flagged by a one-cycle done pulse together with borrow-out (out==0).
// Used by convolution control to track the remaining elements, rows or
// kernel taps. Instances can be chained: one block's bout/done can drive the
// next block's en/start.
//
// Parameters:
//   WIDTH        counter width in bits
//   AUTO_RELOAD  1 = restart from the stored load value after each done
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous reset, active-low (0 = reset)
//   start   in   load request, accepted only while ready=1
//   ld_val  in   start count, sampled when start is accepted
//   en      in   decrement enable, acts only while busy
//   abort   in   cancel the current count (acts in RUN and DONE)
//   out     out  current count (registered)
//   bout    out  borrow-out, combinational, high when out==0
//   ready   out  idle, a new start will be accepted
//   busy    out  counting
//   done    out  one-cycle pulse per completed count
// ---------------------------------------------------------------------------
module down_counter_seq #(
    parameter int WIDTH       = 4,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rl;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    // Final decrement: out==1 goes to 0 and completes the count. Comparing
    // with <= keeps the counter from ever wrapping below zero.
    logic w_last;
    assign w_last = (r_out <= ONE);

    // Restart path after DONE, only when reloading is enabled and the stored
    // count is non-zero (a zero-length reload would pulse done forever).
    logic w_reload;
    assign w_reload = (AUTO_RELOAD != 0) && (r_rl != ZERO);

    // The status flags are registered next to the state so they are glitch-
    // free; each transition sets all three to match the new state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_out   <= ZERO;
            r_rl    <= ZERO;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_out <= ld_val;
                        r_rl  <= ld_val;
                        if (ld_val != ZERO) begin
                            r_state <= S_RUN;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end else begin
                            // Zero-length count completes immediately.
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        r_out   <= ZERO;
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (en) begin
                        if (w_last) begin
                            r_out   <= ZERO;
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_out <= r_out - ONE;
                        end
                    end
                end

                S_DONE: begin
                    if (!abort && w_reload) begin
                        r_out   <= r_rl;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end

                default: begin
                    r_out   <= ZERO;
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign out   = r_out;
    assign bout  = (r_out == ZERO);
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_down_counter_seq.sv
module tb_down_counter_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;

    logic         s0, e0, a0;
    logic [W-1:0] l0;
    logic [W-1:0] o0;
    logic         b0, r0, bz0, d0;

    logic         s1, e1, a1;
    logic [W-1:0] l1;
    logic [W-1:0] o1;
    logic         b1, r1, bz1, d1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    down_counter_seq #(.WIDTH(W), .AUTO_RELOAD(0)) u0 (
        .clk(clk), .rst(rst), .start(s0), .ld_val(l0), .en(e0), .abort(a0),
        .out(o0), .bout(b0), .ready(r0), .busy(bz0), .done(d0)
    );

    down_counter_seq #(.WIDTH(W), .AUTO_RELOAD(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .ld_val(l1), .en(e1), .abort(a1),
        .out(o1), .bout(b1), .ready(r1), .busy(bz1), .done(d1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk0(input string nm, input int out, input int rdy, input int bsy, input int dn);
        chk({nm, ".out"},   int'(o0),  out);
        chk({nm, ".ready"}, int'(r0),  rdy);
        chk({nm, ".busy"},  int'(bz0), bsy);
        chk({nm, ".done"},  int'(d0),  dn);
        chk({nm, ".bout"},  int'(b0),  (out == 0) ? 1 : 0);
    endtask

    task automatic chk1(input string nm, input int out, input int rdy, input int bsy, input int dn);
        chk({nm, ".out"},   int'(o1),  out);
        chk({nm, ".ready"}, int'(r1),  rdy);
        chk({nm, ".busy"},  int'(bz1), bsy);
        chk({nm, ".done"},  int'(d1),  dn);
        chk({nm, ".bout"},  int'(b1),  (out == 0) ? 1 : 0);
    endtask

    // Table vectors: inputs applied for one cycle, outputs expected after it.
    typedef struct {
        logic         st;
        logic [W-1:0] ld;
        logic         en;
        logic         ab;
        int           out;
        int           rdy;
        int           bsy;
        int           dn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input int ld, input logic en, input logic ab,
                                input int out, input int rdy, input int bsy, input int dn);
        vec_t v;
        v.st = st; v.ld = W'(ld); v.en = en; v.ab = ab;
        v.out = out; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    // Reference model: remaining count plus a phase (0 idle, 1 counting,
    // 2 finishing) per instance, stepped from the behavioural rules.
    int m_phase[2];
    int m_cnt[2];
    int m_rl[2];

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0; m_cnt[i] = 0; m_rl[i] = 0;
        end
    endfunction

    function automatic void m_step(input int i, input int ar, input logic st, input int ld,
                                   input logic en, input logic ab);
        if (m_phase[i] == 0) begin
            if (st) begin
                m_cnt[i] = ld;
                m_rl[i]  = ld;
                m_phase[i] = (ld > 0) ? 1 : 2;
            end
        end else if (m_phase[i] == 1) begin
            if (ab) begin
                m_cnt[i] = 0;
                m_phase[i] = 0;
            end else if (en) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) m_phase[i] = 2;
            end
        end else begin
            if (!ab && ar != 0 && m_rl[i] != 0) begin
                m_cnt[i] = m_rl[i];
                m_phase[i] = 1;
            end else begin
                m_phase[i] = 0;
            end
        end
    endfunction

    initial begin
        int k;
        rst = 1'b1;
        s0 = 0; e0 = 0; a0 = 0; l0 = '0;
        s1 = 0; e1 = 0; a1 = 0; l1 = '0;

        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        #1;
        chk0("reset_u0", 0, 1, 0, 0);
        chk1("reset_u1", 0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // ---------------- table-driven vectors on u0 ----------------
        // basic count 5
        tbl.push_back(mk(1, 5, 1, 0, 5, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        // start coinciding with done is ignored
        tbl.push_back(mk(1, 7, 1, 0, 0, 1, 0, 0));
        // gapped enable with load 3
        tbl.push_back(mk(1, 3, 0, 0, 3, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
        // zero-length load; en during DONE ignored
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0));
        // en/abort ignored in IDLE
        tbl.push_back(mk(0, 9, 1, 1, 0, 1, 0, 0));
        // abort priority over en
        tbl.push_back(mk(1, 6, 0, 0, 6, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 5, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 2, 0, 1, 0));
        // start in RUN is ignored, ld_val not resampled
        tbl.push_back(mk(1, 9, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            s0 = tbl[i].st; l0 = tbl[i].ld; e0 = tbl[i].en; a0 = tbl[i].ab;
            @(posedge clk);
            #1;
            chk0($sformatf("tbl%0d", i), tbl[i].out, tbl[i].rdy, tbl[i].bsy, tbl[i].dn);
        end
        @(negedge clk);
        s0 = 0; e0 = 0; a0 = 0; l0 = '0;

        // ---------------- reset mid-RUN ----------------
        @(negedge clk) begin s0 = 1; l0 = 4'd9; end
        @(negedge clk) begin s0 = 0; e0 = 1; end
        repeat (3) @(posedge clk);
        #1 chk0("midrun_pre", 6, 0, 1, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk0("midrun_async", 0, 1, 0, 0);
        @(posedge clk);
        #1 chk0("midrun_held", 0, 1, 0, 0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk0("midrun_after", 0, 1, 0, 0);
        end

        // ---------------- max load, no wrap ----------------
        @(negedge clk) begin s0 = 1; l0 = 4'd15; e0 = 0; end
        @(posedge clk);
        #1 chk0("max_load", 15, 0, 1, 0);
        s0 = 0; e0 = 1;
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (d0) break;
            chk("max_out", int'(o0), 15 - k);
        end
        chk("max_latency", k, 15);
        chk0("max_done", 0, 0, 0, 1);
        e0 = 0;
        @(posedge clk);
        #1 chk0("max_idle", 0, 1, 0, 0);

        // ---------------- AUTO_RELOAD on u1 ----------------
        @(negedge clk) begin s1 = 1; l1 = 4'd2; e1 = 1; end
        @(posedge clk);
        #1 chk1("ar_load", 2, 0, 1, 0);
        s1 = 0;
        for (int i = 0; i < 8; i++) begin
            int eo;
            @(posedge clk);
            #1;
            eo = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 0 : 2);
            chk1($sformatf("ar_seq%0d", i), eo, 0, (eo != 0) ? 1 : 0, (eo == 0) ? 1 : 0);
        end
        a1 = 1;
        @(posedge clk);
        #1 chk1("ar_abort_done", 0, 1, 0, 0);
        a1 = 0; e1 = 0;

        // ---------------- randomized vs model ----------------
        @(negedge clk) rst = 1'b0;
        m_reset();
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            s0 = ($urandom_range(0, 3) == 0); e0 = $urandom_range(0, 1) != 0;
            a0 = ($urandom_range(0, 15) == 0); l0 = W'($urandom_range(0, 15));
            s1 = ($urandom_range(0, 3) == 0); e1 = $urandom_range(0, 1) != 0;
            a1 = ($urandom_range(0, 15) == 0); l1 = W'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                m_reset();
            end else begin
                rst = 1'b1;
                m_step(0, 0, s0, int'(l0), e0, a0);
                m_step(1, 1, s1, int'(l1), e1, a1);
            end
            @(posedge clk);
            #1;
            chk0("rnd_u0", m_cnt[0], (m_phase[0] == 0) ? 1 : 0,
                 (m_phase[0] == 1) ? 1 : 0, (m_phase[0] == 2) ? 1 : 0);
            chk1("rnd_u1", m_cnt[1], (m_phase[1] == 0) ? 1 : 0,
                 (m_phase[1] == 1) ? 1 : 0, (m_phase[1] == 2) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
